// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL reset pulse, lock qualification and video reset release.
// Optional macro PLL_RESET_SEQ_LOSS_COUNT_EN enables the lock-loss event counter.
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RELOCK_TIMEOUT     = 65536,
    parameter int UNLOCK_FILTER      = 4
) (
    input  logic       in_clk25,
    input  logic       in_reset,
    input  logic       in_locked,
    input  logic       in_force_relock,
    output logic       out_pll_rst,
    output logic       out_video_rst,
    output logic       out_ready,
    output logic [1:0] out_state,
    output logic [7:0] out_loss_count
);

    typedef enum logic [1:0] {
        S_PLLRST = 2'd0,
        S_WAIT   = 2'd1,
        S_STABLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    // Terminal counts; every parameter is at most 2^24 so N-1 fits in 24 bits.
    localparam logic [23:0] L_RST_LAST = 24'(PLL_RST_CYCLES - 1);
    localparam logic [23:0] L_STB_LAST = 24'(LOCK_STABLE_CYCLES - 1);
    localparam logic [23:0] L_TMO_LAST = 24'(RELOCK_TIMEOUT - 1);
    localparam logic [23:0] L_FLT_LAST = 24'(UNLOCK_FILTER - 1);

    logic        r_sync_meta;
    logic        r_lk;
    state_t      r_state;
    logic [23:0] r_cnt;
    state_t      w_state_nxt;
    logic [23:0] w_cnt_nxt;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge in_clk25) begin
        if (in_reset) begin
            r_sync_meta <= 1'b0;
            r_lk        <= 1'b0;
        end else begin
            r_sync_meta <= in_locked;
            r_lk        <= r_sync_meta;
        end
    end

    // State register and the single shared cycle counter.
    always_ff @(posedge in_clk25) begin
        if (in_reset) begin
            r_state <= S_PLLRST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic; a forced relock overrides every state but PLLRST.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 24'd1;
        unique case (r_state)
            S_PLLRST: begin
                if (r_cnt == L_RST_LAST) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (r_lk) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == L_TMO_LAST) begin
                    w_state_nxt = S_PLLRST;
                    w_cnt_nxt   = '0;
                end
            end
            S_STABLE: begin
                if (!r_lk) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == L_STB_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (r_lk) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == L_FLT_LAST) begin
                    w_state_nxt = S_PLLRST;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_PLLRST;
                w_cnt_nxt   = '0;
            end
        endcase
        if (in_force_relock && (r_state != S_PLLRST)) begin
            w_state_nxt = S_PLLRST;
            w_cnt_nxt   = '0;
        end
    end

    // Outputs are pure decodes of the state register.
    assign out_pll_rst   = (r_state == S_PLLRST);
    assign out_video_rst = (r_state != S_RUN);
    assign out_ready     = (r_state == S_RUN);
    assign out_state     = r_state;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic       w_loss_evt;
    logic [7:0] r_loss_count;

    // A loss is the filtered low-lock exit from RUN, independent of a coincident force.
    assign w_loss_evt = (r_state == S_RUN) && !r_lk && (r_cnt == L_FLT_LAST);

    // Saturating lock-loss event counter.
    always_ff @(posedge in_clk25) begin
        if (in_reset) begin
            r_loss_count <= 8'd0;
        end else if (w_loss_evt && (r_loss_count != 8'hFF)) begin
            r_loss_count <= r_loss_count + 8'd1;
        end
    end

    assign out_loss_count = r_loss_count;
`else
    assign out_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed checks of the PLL reset sequencer.
// Expected loss counts follow PLL_RESET_SEQ_LOSS_COUNT_EN when it is defined.
module tb_pll_reset_seq;

    localparam int P_RST = 4;
    localparam int P_STB = 8;
    localparam int P_TMO = 32;
    localparam int P_FLT = 3;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    localparam bit LC_EN = 1'b1;
`else
    localparam bit LC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       force_rl;
    logic       pll_rst;
    logic       video_rst;
    logic       ready;
    logic [1:0] state;
    logic [7:0] loss;

    int checks = 0;
    int errors = 0;
    int n_loss = 0;

    pll_reset_seq #(
        .PLL_RST_CYCLES    (P_RST),
        .LOCK_STABLE_CYCLES(P_STB),
        .RELOCK_TIMEOUT    (P_TMO),
        .UNLOCK_FILTER     (P_FLT)
    ) dut (
        .in_clk25       (clk),
        .in_reset       (rst),
        .in_locked      (locked),
        .in_force_relock(force_rl),
        .out_pll_rst    (pll_rst),
        .out_video_rst  (video_rst),
        .out_ready      (ready),
        .out_state      (state),
        .out_loss_count (loss)
    );

    always #20 clk = ~clk;

    function automatic int loss_exp(input int n);
        if (!LC_EN) return 0;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (state === target) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        locked = 1'b0;
        force_rl = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got %0d want 0", state);
        end
        checks++;
        if (pll_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_pll_rst got %0b want 1", pll_rst);
        end
        checks++;
        if (video_rst !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_video got %0b/%0b want 1/0", video_rst, ready);
        end
        checks++;
        if (loss !== 8'd0) begin
            errors++;
            $display("FAIL reset_loss got %0d want 0", loss);
        end
    endtask

    task automatic test_lock_seq();
        logic [1:0] exp;
        locked = 1'b1;
        apply_reset();
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp = (k <= 3) ? 2'd0 : (k == 4) ? 2'd1 : (k <= 12) ? 2'd2 : 2'd3;
            checks++;
            if (state !== exp || pll_rst !== (exp == 2'd0) ||
                video_rst !== (exp != 2'd3) || ready !== (exp == 2'd3)) begin
                errors++;
                $display("FAIL lock_seq k=%0d got st=%0d pr=%0b vr=%0b rd=%0b want st=%0d",
                         k, state, pll_rst, video_rst, ready, exp);
            end
        end
    endtask

    task automatic test_no_lock();
        logic [1:0] exp;
        locked = 1'b0;
        apply_reset();
        for (int k = 1; k <= 80; k++) begin
            tick();
            exp = ((k % 36) < 4) ? 2'd0 : 2'd1;
            checks++;
            if (state !== exp || ready !== 1'b0) begin
                errors++;
                $display("FAIL no_lock k=%0d got st=%0d rd=%0b want st=%0d rd=0",
                         k, state, ready, exp);
            end
        end
    endtask

    task automatic test_stable_glitch();
        logic [1:0] exp;
        locked = 1'b1;
        apply_reset();
        for (int k = 1; k <= 21; k++) begin
            tick();
            exp = (k <= 3) ? 2'd0 : (k == 4) ? 2'd1 : (k <= 10) ? 2'd2 :
                  (k == 11) ? 2'd1 : (k <= 19) ? 2'd2 : 2'd3;
            checks++;
            if (state !== exp) begin
                errors++;
                $display("FAIL stable_glitch k=%0d got %0d want %0d", k, state, exp);
            end
            if (k == 8) locked = 1'b0;
            if (k == 9) locked = 1'b1;
        end
    endtask

    task automatic test_run_loss();
        locked = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 2) locked = 1'b1;
            checks++;
            if (state !== 2'd3) begin
                errors++;
                $display("FAIL run_drop2 e=%0d got %0d want 3", e, state);
            end
        end
        locked = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 3) locked = 1'b1;
            checks++;
            if (state !== 2'd3) begin
                errors++;
                $display("FAIL run_drop3_hold e=%0d got %0d want 3", e, state);
            end
        end
        tick();
        n_loss++;
        checks++;
        if (state !== 2'd0 || video_rst !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL run_loss got st=%0d vr=%0b rd=%0b want 0/1/0",
                     state, video_rst, ready);
        end
        checks++;
        if (loss !== 8'(loss_exp(n_loss))) begin
            errors++;
            $display("FAIL run_loss_count got %0d want %0d", loss, loss_exp(n_loss));
        end
    endtask

    task automatic test_force_loss();
        bit ok;
        wait_state(2'd3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL force_wait_run got %0d want 3", state);
        end
        locked = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 3) locked = 1'b1;
        end
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL force_pre got %0d want 3", state);
        end
        force_rl = 1'b1;
        tick();
        n_loss++;
        checks++;
        if (state !== 2'd0 || loss !== 8'(loss_exp(n_loss))) begin
            errors++;
            $display("FAIL force_loss got st=%0d loss=%0d want 0/%0d",
                     state, loss, loss_exp(n_loss));
        end
        for (int e = 6; e <= 9; e++) begin
            if (e == 8) force_rl = 1'b0;
            tick();
            checks++;
            if (state !== ((e == 9) ? 2'd1 : 2'd0)) begin
                errors++;
                $display("FAIL force_pllrst e=%0d got %0d want %0d",
                         e, state, (e == 9) ? 1 : 0);
            end
        end
        checks++;
        if (loss !== 8'(loss_exp(n_loss))) begin
            errors++;
            $display("FAIL force_single got %0d want %0d", loss, loss_exp(n_loss));
        end
        tick();
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL force_stable got %0d want 2", state);
        end
        force_rl = 1'b1;
        tick();
        force_rl = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL force_in_stable got %0d want 0", state);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        while (n_loss < 258) begin
            wait_state(2'd3, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL sat_wait_run got %0d want 3", state);
                return;
            end
            locked = 1'b0;
            repeat (3) tick();
            locked = 1'b1;
            tick();
            tick();
            n_loss++;
            checks++;
            if (state !== 2'd0 || loss !== 8'(loss_exp(n_loss))) begin
                errors++;
                $display("FAIL saturate n=%0d got st=%0d loss=%0d want 0/%0d",
                         n_loss, state, loss, loss_exp(n_loss));
            end
        end
    endtask

    task automatic test_reset_stable();
        bit ok;
        wait_state(2'd2, ok);
        tick();
        checks++;
        if (!ok || state !== 2'd2) begin
            errors++;
            $display("FAIL rst_wait_stable got %0d want 2", state);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (state !== 2'd0 || pll_rst !== 1'b1 || loss !== 8'd0) begin
            errors++;
            $display("FAIL rst_stable got st=%0d pr=%0b loss=%0d want 0/1/0",
                     state, pll_rst, loss);
        end
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if (state !== ((e <= 3) ? 2'd0 : (e == 4) ? 2'd1 : 2'd2)) begin
                errors++;
                $display("FAIL rst_restart e=%0d got %0d", e, state);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_seq();
        test_no_lock();
        test_stable_glitch();
        test_run_loss();
        test_force_loss();
        test_saturate();
        test_reset_stable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
